// File: rtl/sigma_delta_decimator_pkg.sv
// -----------------------------------------------------------------------------
// sigma_delta_decimator_pkg
// Shared audio definitions for the sigma-delta receive path: CIC order,
// default decimation, PCM width, and the unsigned/signed PCM convention used
// by the synth (signed = unsigned xor 0x8000).
// -----------------------------------------------------------------------------
package sigma_delta_decimator_pkg;

  localparam int CIC_ORDER        = 3;
  localparam int DEC_LOG2_DEFAULT = 10;
  localparam int PCM_W            = 16;

  localparam logic [PCM_W-1:0] PCM_SIGN_FLIP = 16'h8000;

  typedef logic [PCM_W-1:0] pcm_t;

  // Warmup tracking: the first three loads after reset carry the filter
  // transient and are dropped; WARM_DONE is sticky until the next reset.
  typedef enum logic [1:0] {
    WARM_SKIP0 = 2'd0,
    WARM_SKIP1 = 2'd1,
    WARM_SKIP2 = 2'd2,
    WARM_DONE  = 2'd3
  } warmup_e;

  // CIC register width: N*log2(R) bits of growth plus one bit so the exact
  // full-scale value R^N is representable, plus one guard bit.
  function automatic int cic_width(input int dec_log2);
    return CIC_ORDER * dec_log2 + 2;
  endfunction

  // Offset-binary <-> two's complement; the mapping is its own inverse.
  function automatic pcm_t to_signed_pcm(input pcm_t unsigned_pcm);
    return unsigned_pcm ^ PCM_SIGN_FLIP;
  endfunction

endpackage

// File: rtl/sigma_delta_decimator_cic_sinc3.sv
// -----------------------------------------------------------------------------
// sigma_delta_decimator_cic_sinc3
// Third-order CIC (sinc3) decimator core. Three free-running integrators run at
// the input rate; once per R cycles the integrator output is captured into a
// three-stage comb pipeline clocked one stage per cycle.
//
// Ports
//   clk      in   1   sample clock, one input bit per cycle
//   rst_n    in   1   asynchronous active-low reset
//   x_i      in   1   synchronised input bit
//   comb_o   out  W   comb output, valid while load_o is high; range [0, R^3]
//   load_o   out  1   single-cycle strobe, 3 cycles after the capture cycle
// -----------------------------------------------------------------------------
module sigma_delta_decimator_cic_sinc3
  import sigma_delta_decimator_pkg::*;
#(
  parameter  int DEC_LOG2 = DEC_LOG2_DEFAULT,
  localparam int W        = cic_width(DEC_LOG2)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         x_i,
  output logic [W-1:0] comb_o,
  output logic         load_o
);

  localparam logic [DEC_LOG2-1:0] DEC_LAST = '1;

  logic [W-1:0]        i1_q, i2_q, i3_q;
  logic [W-1:0]        d1_q, d2_q, d3_q;
  logic [W-1:0]        c1_q, c2_q, c3_q;
  logic [DEC_LOG2-1:0] dec_cnt_q;
  // stage_q[k] marks that comb stage k+1 holds a fresh value this cycle.
  logic [2:0]          stage_q;
  logic                capture;

  assign capture = (dec_cnt_q == DEC_LAST);

  // Integrator growth wraps modulo 2^W; the combs undo the wrap exactly, so
  // no saturation is needed anywhere in the datapath.
  // NOTE: every register here is written with <= so all stages see the
  // previous cycle's values, which is what the integrator/comb equations mean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      c3_q      <= '0;
      dec_cnt_q <= '0;
      stage_q   <= '0;
    end else begin
      i1_q      <= i1_q + {{(W-1){1'b0}}, x_i};
      i2_q      <= i2_q + i1_q;
      i3_q      <= i3_q + i2_q;
      dec_cnt_q <= dec_cnt_q + 1'b1;
      stage_q   <= {stage_q[1:0], capture};

      if (capture) begin
        c1_q <= i3_q - d1_q;
        d1_q <= i3_q;
      end
      if (stage_q[0]) begin
        c2_q <= c1_q - d2_q;
        d2_q <= c1_q;
      end
      if (stage_q[1]) begin
        c3_q <= c2_q - d3_q;
        d3_q <= c2_q;
      end
    end
  end

  assign comb_o = c3_q;
  assign load_o = stage_q[2];

endmodule

// File: rtl/sigma_delta_decimator.sv
// -----------------------------------------------------------------------------
// sigma_delta_decimator
// Receive side of the 1-bit sigma-delta audio output. Synchronises the
// bitstream, filters and decimates it with a sinc3 CIC, scales the result to
// 16-bit unsigned PCM and hands samples to a consumer over valid/ready with a
// one-entry holding register and a sticky overrun flag.
//
// Parameters
//   DEC_LOG2     log2 of decimation ratio R (needs 3*DEC_LOG2 >= 16)
//   SYNC_STAGES  synchroniser depth on pdm_in, legal values 2..3
//
// Ports
//   clk48         in   1   system clock, one PDM bit per cycle
//   rst_n         in   1   asynchronous active-low reset
//   pdm_in        in   1   sigma-delta bitstream, may be asynchronous
//   sample_data   out  16  unsigned PCM (0x0000 all zeros, 0xFFFF all ones)
//   sample_valid  out  1   sample_data holds an unconsumed sample
//   sample_ready  in   1   consumer accepts when valid && ready
//   overrun       out  1   sticky: a held sample was overwritten unaccepted
//   overrun_clr   in   1   synchronous clear of overrun (a new overrun wins)
// -----------------------------------------------------------------------------
module sigma_delta_decimator
  import sigma_delta_decimator_pkg::*;
#(
  parameter int DEC_LOG2    = DEC_LOG2_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk48,
  input  logic             rst_n,
  input  logic             pdm_in,
  output logic [PCM_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int W = cic_width(DEC_LOG2);
  // R^3: the only comb value whose top PCM bits would otherwise read as zero.
  localparam logic [W-1:0] FULL_SCALE = W'(1) << (CIC_ORDER * DEC_LOG2);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_in};
    end
  end

  // ---------------------------------------------------------------------------
  // CIC core
  // ---------------------------------------------------------------------------
  logic [W-1:0] comb;
  logic         load;

  sigma_delta_decimator_cic_sinc3 #(
    .DEC_LOG2 (DEC_LOG2)
  ) u_cic (
    .clk    (clk48),
    .rst_n  (rst_n),
    .x_i    (sync_q[SYNC_STAGES-1]),
    .comb_o (comb),
    .load_o (load)
  );

  // ---------------------------------------------------------------------------
  // Scaling: keep the 16 bits just below the R^3 bit; truncation toward zero.
  // ---------------------------------------------------------------------------
  pcm_t sample;

  assign sample = (comb == FULL_SCALE) ? '1
                                       : comb[CIC_ORDER*DEC_LOG2-1 -: PCM_W];

  // ---------------------------------------------------------------------------
  // Warmup, holding register and overrun
  // ---------------------------------------------------------------------------
  warmup_e warm_q, warm_d;
  pcm_t    data_q, data_d;
  logic    valid_q, valid_d;
  logic    overrun_q, overrun_d;
  logic    deliver;
  logic    overrun_set;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    warm_d      = warm_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_set = 1'b0;
    deliver     = load && (warm_q == WARM_DONE);

    if (load && (warm_q != WARM_DONE)) begin
      warm_d = warmup_e'(warm_q + 2'd1);
    end

    if (deliver) begin
      // A same-cycle accept of the old sample is a clean handover.
      overrun_set = valid_q && !sample_ready;
      data_d      = sample;
      valid_d     = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      warm_q    <= WARM_SKIP0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      warm_q    <= warm_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// -----------------------------------------------------------------------------
// tb_sigma_delta_decimator
// Directed bench for sigma_delta_decimator with R = 1024, SYNC_STAGES = 2.
// Timing reference: rst_n is released between edges and cyc counts rising
// edges since release. dec_cnt == cyc mod R, capture k happens in cycle
// k*R-1, its load in cycle k*R+2, and the loaded sample is visible right after
// edge k*R+3. Loads 1..3 are warmup, so the first delivered sample shows at
// cyc = 4*R+3.
// -----------------------------------------------------------------------------
module tb_sigma_delta_decimator;

  localparam int R        = 1024;
  localparam int FIRST_OK = 4 * R + 3;

  logic        clk48 = 1'b0;
  logic        rst_n = 1'b1;
  logic        pdm_in = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun;
  logic        overrun_clr = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;

  // Stimulus source: 0 = constant level, 1 = toggle, 2 = first-order
  // sigma-delta modulator of sdm_val (the synth's output stage).
  int          mode = 0;
  logic        pdm_level = 1'b0;
  logic        tog = 1'b0;
  logic [15:0] sdm_val = 16'h0;
  logic [16:0] sdm_acc = 17'h0;

  always #5 clk48 = ~clk48;

  sigma_delta_decimator #(
    .DEC_LOG2    (10),
    .SYNC_STAGES (2)
  ) dut (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .pdm_in       (pdm_in),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive the next PDM bit, advance one clock, sample 1 time unit later.
  task automatic tick();
    case (mode)
      0: pdm_in = pdm_level;
      1: begin
        tog    = ~tog;
        pdm_in = tog;
      end
      default: begin
        sdm_acc = {1'b0, sdm_acc[15:0]} + {1'b0, sdm_val};
        pdm_in  = sdm_acc[16];
      end
    endcase
    @(posedge clk48);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int upto);
    while (cyc < upto) tick();
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk48);
      #1;
    end
    sdm_acc = '0;
    tog     = 1'b0;
    rst_n   = 1'b1;
    cyc     = 0;
  endtask

  // Run with sample_ready high; every valid cycle must carry exp.
  task automatic run_deliver(input int upto, input string tag,
                             input logic [15:0] exp,
                             output int n_seen, output int first);
    n_seen = 0;
    first  = -1;
    while (cyc < upto) begin
      tick();
      if (sample_valid) begin
        if (n_seen == 0) first = cyc;
        n_seen++;
        check(tag, {16'h0, sample_data}, {16'h0, exp});
      end
    end
  endtask

  int          n_seen;
  int          first;
  logic [15:0] sdm_vals [4] = '{16'h2000, 16'h4000, 16'h6000, 16'hC000};

  initial begin
    // Reset state
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_data", {16'h0, sample_data}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);

    // 1. All ones: full scale, one pulse per R, nothing during warmup.
    mode = 0; pdm_level = 1'b1; sample_ready = 1'b1;
    reset_dut();
    run_deliver(6 * R + 5, "ones_data", 16'hFFFF, n_seen, first);
    check("ones_count", n_seen, 3);
    check("ones_first", first, FIRST_OK);

    // 2. All zeros.
    pdm_level = 1'b0;
    reset_dut();
    run_deliver(6 * R + 5, "zeros_data", 16'h0000, n_seen, first);
    check("zeros_count", n_seen, 3);
    check("zeros_overrun", {31'h0, overrun}, 32'h0);

    // 3. Alternating bits: sinc3 with even R has a null at Nyquist, so the
    // output is exactly R^3/2 -> 0x8000 regardless of phase.
    mode = 1;
    reset_dut();
    run_deliver(6 * R + 5, "toggle_data", 16'h8000, n_seen, first);
    check("toggle_count", n_seen, 3);

    // 4. Loopback from a first-order modulator. Each value gives a periodic
    // pattern whose period divides R, so the CIC output is exactly R^3 times
    // the ones density, i.e. the PCM value itself.
    mode = 2;
    foreach (sdm_vals[i]) begin
      sdm_val = sdm_vals[i];
      reset_dut();
      run_deliver(5 * R + 5, $sformatf("sdm_%h_data", sdm_val), sdm_val,
                  n_seen, first);
      check($sformatf("sdm_%h_count", sdm_val), n_seen, 2);
    end

    // 5. Back-pressure and overrun.
    mode = 0; pdm_level = 1'b1; sample_ready = 1'b0;
    reset_dut();
    run_to(FIRST_OK);
    check("bp_first_valid", {31'h0, sample_valid}, 32'h1);
    check("bp_first_data", {16'h0, sample_data}, 32'hFFFF);
    check("bp_first_overrun", {31'h0, overrun}, 32'h0);
    pdm_level = 1'b0;
    run_to(4 * R + 500);
    check("bp_hold_data", {16'h0, sample_data}, 32'hFFFF);
    run_to(5 * R + 3);
    check("bp_overrun_set", {31'h0, overrun}, 32'h1);
    check("bp_still_valid", {31'h0, sample_valid}, 32'h1);
    // Capture 8's window lies entirely after the switch to zeros.
    run_to(8 * R + 3);
    check("bp_newest_data", {16'h0, sample_data}, 32'h0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("bp_overrun_clr", {31'h0, overrun}, 32'h0);
    // Clear coincident with the overwrite at edge 9R+3: set wins.
    run_to(9 * R + 2);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("bp_clr_vs_set", {31'h0, overrun}, 32'h1);
    sample_ready = 1'b1;
    tick();
    check("bp_accept", {31'h0, sample_valid}, 32'h0);

    // 6. Reset mid-frame (dec_cnt = 500) with a held sample and overrun set.
    pdm_level = 1'b1; sample_ready = 1'b0;
    reset_dut();
    run_to(5 * R + 500);
    check("mid_pre_valid", {31'h0, sample_valid}, 32'h1);
    check("mid_pre_overrun", {31'h0, overrun}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {16'h0, sample_data}, 32'h0);
    check("mid_rst_valid", {31'h0, sample_valid}, 32'h0);
    check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
    sample_ready = 1'b1;
    reset_dut();
    run_deliver(4 * R + 5, "mid_after_data", 16'hFFFF, n_seen, first);
    check("mid_after_count", n_seen, 1);
    check("mid_after_first", first, FIRST_OK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
